// File: rtl/uart_hub_pkg.sv
// Shared types and width helpers for the UART stream hub and its FIFOs.
package uart_hub_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } tx_state_e;

    localparam logic [7:0] DEF_CMD_CHAR = 8'h54;
    localparam int         DEF_DEPTH    = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hub_fifo.sv
// First-word fall-through FIFO; a push at full is taken when a pop happens in the same cycle.
module hub_fifo
    import uart_hub_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DW-1:0]               push_data,
    input  logic                        pop,
    output logic [DW-1:0]               head,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & (~full | pop);
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_stream_hub.sv
// Merges NCH byte-stream producers into one uart TX stream (round-robin, message lock)
// and buffers received bytes, turning the command byte into a per-channel request pulse.
module uart_stream_hub
    import uart_hub_pkg::*;
#(
    parameter int         NCH      = 4,
    parameter int         DEPTH    = DEF_DEPTH,
    parameter logic [7:0] CMD_CHAR = DEF_CMD_CHAR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NCH-1:0]              ch_valid,
    input  logic [NCH*8-1:0]            ch_data,
    input  logic [NCH-1:0]              ch_last,
    output logic [NCH-1:0]              ch_ready,
    input  logic [$clog2(NCH)-1:0]      mode_sel,
    output logic [NCH-1:0]              cmd_req,
    output logic                        utx_start,
    output logic [7:0]                  utx_data,
    input  logic                        utx_busy,
    input  logic [7:0]                  urx_data,
    input  logic                        urx_done,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [cnt_width(DEPTH)-1:0] tx_count,
    output logic [cnt_width(DEPTH)-1:0] rx_count,
    output logic                        rx_overflow,
    input  logic                        ovf_clr
);

    localparam int CH_W = $clog2(NCH);

    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;
    logic            lock_q, lock_d;
    logic [NCH-1:0]  cmd_req_q, cmd_req_d;
    logic            rx_overflow_q, rx_overflow_d;

    logic            gnt_any;
    logic [CH_W-1:0] gnt_idx;
    int              idx;

    logic            tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]      tx_push_data, tx_head;
    logic            is_cmd, rx_push, rx_pop, rx_drop, rx_full, rx_empty;

    tx_state_e       state_q;
    logic            utx_start_q;
    logic [7:0]      utx_data_q;

    // A held lock pins the grant; otherwise the first valid channel from rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (lock_q) begin
            gnt_any = 1'b1;
            gnt_idx = lock_ch_q;
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr_q) + k) % NCH;
                if (ch_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CH_W'(idx);
                end
            end
        end
    end

    always_comb begin
        ch_ready     = (gnt_any && !tx_full) ? (NCH'(1) << gnt_idx) : '0;
        tx_push      = gnt_any & ch_valid[gnt_idx] & ~tx_full;
        tx_push_data = ch_data[8*int'(gnt_idx) +: 8];
        lock_d       = lock_q;
        lock_ch_d    = lock_ch_q;
        rr_ptr_d     = rr_ptr_q;
        if (tx_push) begin
            if (ch_last[gnt_idx]) begin
                lock_d   = 1'b0;
                rr_ptr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CH_W'(1);
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = gnt_idx;
            end
        end
    end

    always_comb begin
        is_cmd        = urx_done & (urx_data == CMD_CHAR);
        rx_push       = urx_done & ~is_cmd;
        rx_pop        = rx_valid & rx_ready;
        rx_drop       = rx_push & rx_full & ~rx_pop;
        cmd_req_d     = is_cmd ? (NCH'(1) << mode_sel) : '0;
        rx_overflow_d = rx_drop | (rx_overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            lock_q        <= 1'b0;
            lock_ch_q     <= '0;
            cmd_req_q     <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            lock_q        <= lock_d;
            lock_ch_q     <= lock_ch_d;
            cmd_req_q     <= cmd_req_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    assign tx_pop = (state_q == S_IDLE) & ~tx_empty & ~utx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            utx_start_q <= 1'b0;
            utx_data_q  <= '0;
        end else begin
            utx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_pop) begin
                        utx_data_q  <= tx_head;
                        utx_start_q <= 1'b1;
                        state_q     <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: if (utx_busy) state_q <= S_WAIT_DONE;
                S_WAIT_DONE: if (!utx_busy) state_q <= S_IDLE;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    hub_fifo #(.DW(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    hub_fifo #(.DW(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (urx_data),
        .pop       (rx_pop),
        .head      (rx_data),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign rx_valid    = ~rx_empty;
    assign cmd_req     = cmd_req_q;
    assign rx_overflow = rx_overflow_q;
    assign utx_start   = utx_start_q;
    assign utx_data    = utx_data_q;

endmodule
